// File: rtl/ov7670_pixel_packer.sv
// OV7670 byte-stream to RGB565 pixel packer: pairs sensor bytes into pixels tagged
// with x/y, and flags frame boundaries and line/frame geometry errors (pclk domain).
module ov7670_pixel_packer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic           pclk,
  input  logic           reset,
  input  logic           enable,
  input  logic           vsync,
  input  logic           href,
  input  logic [7:0]     d,
  output logic [15:0]    pixel,
  output logic           pixel_valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           frame_end,
  output logic           line_err,
  output logic           frame_err,
  output logic [15:0]    frame_count
);

  // Internal counters must reach H_ACTIVE / V_ACTIVE themselves (the saturation caps).
  localparam int XC_W = $clog2(H_ACTIVE + 1);
  localparam int YC_W = $clog2(V_ACTIVE + 1);
  localparam logic [XC_W-1:0] H_MAX = XC_W'(H_ACTIVE);
  localparam logic [YC_W-1:0] V_MAX = YC_W'(V_ACTIVE);

  typedef enum logic [1:0] {SYNC_HIGH, SYNC_LOW, ACTIVE} state_t;

  state_t          state, state_d;
  logic            phase, phase_d;
  logic            overflow, overflow_d;
  logic            extra_line, extra_line_d;
  logic            href_q;
  logic [7:0]      hi_byte, hi_byte_d;
  logic [XC_W-1:0] x_cnt, x_cnt_d;
  logic [YC_W-1:0] y_cnt, y_cnt_d;

  logic [15:0]     pixel_d;
  logic            pixel_valid_d;
  logic [X_W-1:0]  x_d;
  logic [Y_W-1:0]  y_d;
  logic            frame_start_d, frame_end_d, line_err_d, frame_err_d;
  logic [15:0]     frame_count_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d       = state;
    phase_d       = phase;
    overflow_d    = overflow;
    extra_line_d  = extra_line;
    hi_byte_d     = hi_byte;
    x_cnt_d       = x_cnt;
    y_cnt_d       = y_cnt;
    pixel_d       = pixel;
    x_d           = x;
    y_d           = y;
    pixel_valid_d = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count;

    if (!enable) begin
      state_d = SYNC_HIGH;
    end else begin
      case (state)
        SYNC_HIGH: if (vsync) state_d = SYNC_LOW;
        SYNC_LOW: begin
          if (!vsync) begin
            state_d      = ACTIVE;
            x_cnt_d      = '0;
            y_cnt_d      = '0;
            phase_d      = 1'b0;
            overflow_d   = 1'b0;
            extra_line_d = 1'b0;
          end
        end
        ACTIVE: begin
          if (vsync) begin
            // Frame close takes priority over any line still in progress.
            frame_end_d   = 1'b1;
            frame_err_d   = (y_cnt != V_MAX) || extra_line;
            frame_count_d = frame_count + 16'd1;
            state_d       = SYNC_LOW;
          end else if (href) begin
            phase_d = !phase;
            if (!phase) begin
              hi_byte_d = d;
            end else if (x_cnt < H_MAX && y_cnt < V_MAX) begin
              pixel_valid_d = 1'b1;
              pixel_d       = {hi_byte, d};
              x_d           = X_W'(x_cnt);
              y_d           = Y_W'(y_cnt);
              frame_start_d = (x_cnt == '0) && (y_cnt == '0);
              x_cnt_d       = x_cnt + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (href_q) begin
            line_err_d = phase || (x_cnt != H_MAX) || overflow;
            x_cnt_d    = '0;
            phase_d    = 1'b0;
            overflow_d = 1'b0;
            // y saturates; a line closing at the cap still marks the frame as too tall.
            if (y_cnt == V_MAX) extra_line_d = 1'b1;
            else                y_cnt_d      = y_cnt + 1'b1;
          end
        end
        default: state_d = SYNC_HIGH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state       <= SYNC_HIGH;
      phase       <= 1'b0;
      overflow    <= 1'b0;
      extra_line  <= 1'b0;
      href_q      <= 1'b0;
      hi_byte     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_d;
      phase       <= phase_d;
      overflow    <= overflow_d;
      extra_line  <= extra_line_d;
      href_q      <= href;
      hi_byte     <= hi_byte_d;
      x_cnt       <= x_cnt_d;
      y_cnt       <= y_cnt_d;
      pixel       <= pixel_d;
      pixel_valid <= pixel_valid_d;
      x           <= x_d;
      y           <= y_d;
      frame_start <= frame_start_d;
      frame_end   <= frame_end_d;
      line_err    <= line_err_d;
      frame_err   <= frame_err_d;
      frame_count <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// Bench for ov7670_pixel_packer: directed and random sensor streams checked every cycle
// against a byte/line-counting reference model, plus literal expectations per scenario.
module tb_ov7670_pixel_packer;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  logic           pclk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           vsync = 1'b0;
  logic           href = 1'b0;
  logic [7:0]     d = 8'h00;
  logic [15:0]    pixel;
  logic           pixel_valid;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           frame_start, frame_end, line_err, frame_err;
  logic [15:0]    frame_count;

  always #5 pclk = ~pclk;

  ov7670_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(X_W), .Y_W(Y_W)) dut (
    .pclk(pclk), .reset(reset), .enable(enable), .vsync(vsync), .href(href), .d(d),
    .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
    .frame_start(frame_start), .frame_end(frame_end), .line_err(line_err),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: counts bytes in the current line and lines closed in the frame.
  int          m_mode;  // 0: wait vsync high, 1: wait vsync low, 2: capturing
  int          m_bytes;
  int          m_lines;
  logic [7:0]  m_hi;
  logic        m_prev_href;
  logic        e_valid, e_fs, e_fe, e_le, e_ferr;
  logic [15:0] e_pixel, e_count;
  int          e_x, e_y;

  task automatic model_reset();
    m_mode = 0; m_bytes = 0; m_lines = 0; m_hi = 8'h00; m_prev_href = 1'b0;
    e_valid = 1'b0; e_fs = 1'b0; e_fe = 1'b0; e_le = 1'b0; e_ferr = 1'b0;
    e_pixel = 16'h0000; e_count = 16'h0000; e_x = 0; e_y = 0;
  endtask

  task automatic model_step();
    e_valid = 1'b0; e_fs = 1'b0; e_fe = 1'b0; e_le = 1'b0; e_ferr = 1'b0;
    if (!enable) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (vsync) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!vsync) begin m_mode = 2; m_bytes = 0; m_lines = 0; end
    end else if (vsync) begin
      e_fe = 1'b1; e_ferr = (m_lines != V); e_count = e_count + 16'd1; m_mode = 1;
    end else if (href) begin
      m_bytes++;
      if (m_bytes % 2 == 1) m_hi = d;
      else if (m_bytes / 2 - 1 < H && m_lines < V) begin
        e_valid = 1'b1; e_pixel = {m_hi, d};
        e_x = m_bytes / 2 - 1; e_y = m_lines; e_fs = (e_x == 0 && e_y == 0);
      end
    end else if (m_prev_href) begin
      e_le = (m_bytes != 2 * H) || (m_lines >= V);
      m_bytes = 0; m_lines++;
    end
    m_prev_href = href;
  endtask

  // Event log of DUT outputs for the scenario-level literal expectations.
  logic [15:0] lg_pix[$];
  int          lg_x[$];
  int          lg_y[$];
  logic        lg_fs[$];
  int          cnt_fe = 0, cnt_le = 0, cnt_ferr = 0;

  task automatic compare_and_log();
    check("pixel_valid", pixel_valid, e_valid);
    check("frame_start", frame_start, e_fs);
    check("frame_end", frame_end, e_fe);
    check("line_err", line_err, e_le);
    check("frame_err", frame_err, e_ferr);
    check("frame_count", frame_count, e_count);
    if (e_valid) begin
      check("pixel", pixel, e_pixel);
      check("x", x, e_x);
      check("y", y, e_y);
    end
    if (pixel_valid) begin
      lg_pix.push_back(pixel); lg_x.push_back(int'(x)); lg_y.push_back(int'(y));
      lg_fs.push_back(frame_start);
    end
    if (frame_end) cnt_fe++;
    if (line_err) cnt_le++;
    if (frame_err) cnt_ferr++;
  endtask

  task automatic tick();
    @(posedge pclk);
    if (reset) model_reset(); else model_step();
    @(negedge pclk);
    if (!reset) compare_and_log();
  endtask

  task automatic step(input logic v, input logic h, input logic [7:0] dv);
    tick();
    vsync = v; href = h; d = dv;
  endtask

  task automatic vsync_pulse();
    repeat (3) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int n, input bit seq, input logic [7:0] start);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, seq ? start + 8'(i) : 8'($urandom));
    repeat (2) step(1'b0, 1'b0, 8'h00);
  endtask

  // Line cut short by vsync rising while href is still high.
  task automatic cut_line(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'($urandom));
    step(1'b1, 1'b1, 8'($urandom));
    repeat (2) step(1'b1, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_pix(input string name, input int idx, input logic [15:0] p,
                           input int px, input int py, input logic fs);
    if (idx < lg_pix.size()) begin
      check({name, "_pixel"}, lg_pix[idx], p);
      check({name, "_x"}, lg_x[idx], px);
      check({name, "_y"}, lg_y[idx], py);
      check({name, "_fs"}, lg_fs[idx], fs);
    end else begin
      check({name, "_logged"}, lg_pix.size(), idx + 1);
    end
  endtask

  int b_pix, b_fe, b_le, b_ferr;

  task automatic mark();
    b_pix = lg_pix.size(); b_fe = cnt_fe; b_le = cnt_le; b_ferr = cnt_ferr;
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel", pixel, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h00);
    vsync_pulse();

    // Nominal 4x2 frame, bytes 0x01..0x10.
    mark();
    send_line(8, 1'b1, 8'h01);
    send_line(8, 1'b1, 8'h09);
    vsync_pulse();
    check("nom_npix", lg_pix.size() - b_pix, 8);
    check_pix("nom_first", b_pix, 16'h0102, 0, 0, 1'b1);
    check_pix("nom_last", b_pix + 7, 16'h0F10, 3, 1, 1'b0);
    check("nom_frame_end", cnt_fe - b_fe, 1);
    check("nom_frame_err", cnt_ferr - b_ferr, 0);
    check("nom_frame_count", frame_count, 1);

    // Short first line.
    mark();
    send_line(6, 1'b1, 8'h20);
    send_line(8, 1'b1, 8'h30);
    vsync_pulse();
    check("short_npix", lg_pix.size() - b_pix, 7);
    check("short_line_err", cnt_le - b_le, 1);
    check_pix("short_next", b_pix + 3, 16'h3031, 0, 1, 1'b0);
    check("short_frame_end", cnt_fe - b_fe, 1);
    check("short_frame_err", cnt_ferr - b_ferr, 0);

    // Odd/long line of 9 bytes.
    mark();
    send_line(9, 1'b1, 8'h40);
    send_line(8, 1'b1, 8'h50);
    vsync_pulse();
    check("odd_npix", lg_pix.size() - b_pix, 8);
    check("odd_line_err", cnt_le - b_le, 1);
    check_pix("odd_next", b_pix + 4, 16'h5051, 0, 1, 1'b0);

    // Three lines into a two-line frame.
    mark();
    repeat (3) send_line(8, 1'b1, 8'h60);
    vsync_pulse();
    check("extra_npix", lg_pix.size() - b_pix, 8);
    check("extra_frame_end", cnt_fe - b_fe, 1);
    check("extra_frame_err", cnt_ferr - b_ferr, 1);
    check("extra_frame_count", frame_count, 4);

    // Resync: drop enable mid-frame.
    send_line(8, 1'b1, 8'h70);
    tick(); enable = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    mark();
    send_line(8, 1'b1, 8'h80);
    check("resync_npix", lg_pix.size() - b_pix, 0);
    vsync_pulse();
    check("resync_frame_end", cnt_fe - b_fe, 0);
    check("resync_frame_count", frame_count, 4);
    mark();
    send_line(8, 1'b1, 8'h90);
    check_pix("resync_first", b_pix, 16'h9091, 0, 0, 1'b1);
    vsync_pulse();
    check("resync_close_count", frame_count, 5);

    // Random frames; each closes exactly once.
    for (int f = 0; f < 8; f++) begin
      int nl;
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++)
        send_line(($urandom_range(0, 2) == 0) ? $urandom_range(1, 11) : 8, 1'b0, 8'h00);
      if ($urandom_range(0, 3) == 0) cut_line($urandom_range(1, 6));
      else vsync_pulse();
    end
    check("rand_frame_count", frame_count, 13);

    // Asynchronous reset in the middle of a line.
    repeat (3) step(1'b0, 1'b1, 8'($urandom));
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("arst_pixel", pixel, 0);
    check("arst_x", x, 0);
    check("arst_frame_count", frame_count, 0);
    check("arst_pulses", {pixel_valid, frame_start, frame_end, line_err, frame_err}, 0);
    tick();
    reset = 1'b0;
    mark();
    repeat (3) step(1'b0, 1'b1, 8'($urandom));
    repeat (2) step(1'b0, 1'b0, 8'h00);
    check("arst_quiet_npix", lg_pix.size() - b_pix, 0);
    vsync_pulse();
    mark();
    send_line(8, 1'b1, 8'hA0);
    check_pix("arst_first", b_pix, 16'hA0A1, 0, 0, 1'b1);
    vsync_pulse();
    check("arst_close_count", frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ov7670_pixel_packer.md
# ov7670_pixel_packer

Downstream companion to the OV7670 capture FSM: once the sensor is configured, it turns the raw byte stream from the sensor pins into 16-bit RGB565 pixels. Pairs each two bytes into one pixel tagged with x/y coordinates, and emits frame start/end strobes and line/frame geometry error flags. Runs entirely in the sensor pixel-clock domain. Feeds the frame-buffer writer.

## Interface
- H_ACTIVE, 640: pixels per line (each pixel is 2 bytes on `d`)
- V_ACTIVE, 480: lines per frame
- X_W, 10: width of `x`; must hold H_ACTIVE-1
- Y_W, 9: width of `y`; must hold V_ACTIVE-1
- pclk  in  1  pixel clock from sensor; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  high once sensor register setup is complete; low forces resync
- vsync  in  1  sensor vertical sync, high between frames
- href  in  1  sensor horizontal reference, high during active bytes
- d  in  8  sensor pixel data byte
- pixel  out  16  {first byte, second byte} of the current pixel
- pixel_valid  out  1  one-cycle strobe, `pixel`/`x`/`y` valid
- x  out  X_W  column of `pixel` (0..H_ACTIVE-1)
- y  out  Y_W  row of `pixel` (0..V_ACTIVE-1)
- frame_start  out  1  high together with `pixel_valid` for pixel (0,0)
- frame_end  out  1  one-cycle pulse when a completed frame closes
- line_err  out  1  one-cycle pulse: line byte count ≠ 2*H_ACTIVE
- frame_err  out  1  one-cycle pulse with `frame_end`: line count ≠ V_ACTIVE
- frame_count  out  16  number of frames closed since reset, wraps 0xFFFF→0

## Operation
- Reset: all outputs 0; state SYNC_HIGH; byte phase 0; x=y=0; href_q=0.
- Inputs are sampled directly on the pclk rising edge; href_q holds the previous href.
- State SYNC_HIGH: wait for enable=1 and vsync=1 → SYNC_LOW.
- State SYNC_LOW: vsync=0 → ACTIVE with x=0, y=0, phase=0.
- State ACTIVE:
  - While href=1, phase toggles every cycle.
  - Phase 0: latch d as the high byte.
  - Phase 1: if x<H_ACTIVE and y<V_ACTIVE, emit pixel {hi,d} at (x,y) and increment x. Otherwise drop the pixel, increment nothing, and set an internal overflow flag.
  - href falling edge (href_q=1, href=0): pulse line_err if phase=1, x≠H_ACTIVE, or overflow is set. Then x←0, phase←0, overflow←0, and y saturates at V_ACTIVE.
  - vsync=1: pulse frame_end; pulse frame_err if y≠V_ACTIVE; increment frame_count; → SYNC_LOW.
- enable=0 in any state: → SYNC_HIGH next cycle. The partial frame is discarded: no frame_end, no counter update. Any pixel_valid already issued stands.
- vsync=1 while href=1: the frame-close path wins. The line-end check for that line is skipped.
- Counters never wrap mid-frame. x is capped at H_ACTIVE, y at V_ACTIVE.

## Timing
- Latency: the second byte sampled at edge N gives pixel_valid high during cycle N+1 (registered output).
- Maximum throughput: one pixel every 2 pclk. pixel_valid is never high on two consecutive cycles.
- line_err asserts the cycle after href is sampled low.
- frame_end and frame_err assert the cycle after vsync is sampled high.
- frame_count updates on the same edge that raises frame_end.
- Asynchronous reset mid-line clears outputs immediately. Capture resumes only after a full vsync high→low sequence.

## Test plan
- Nominal: H_ACTIVE=4, V_ACTIVE=2, bytes 0x01..0x10 over 2 lines.
  - Required: 8 pixel_valid strobes, pixel=0x0102 at (0,0) with frame_start, then 0x0F10 at (3,1).
  - Required: frame_end=1, frame_err=0, frame_count=1.
- Short line: 6 bytes on line 0 (H_ACTIVE=4).
  - Required: 3 pixels, line_err pulse, next line starts at x=0, y=1.
  - Required: frame_end with frame_err=0 if 2 lines were sent.
- Odd and long line: 9 bytes on one line.
  - Required: 4 pixels emitted, 9th byte dropped, exactly one line_err pulse.
- Extra line: 3 lines sent with V_ACTIVE=2.
  - Required: no pixel_valid on line 3, frame_err=1 with frame_end.
- Resync: enable=0 mid-frame, then enable=1 while vsync is low.
  - Required: no output until vsync rises and falls, no frame_end, frame_count unchanged.
- Reset mid-line: assert reset for 1 cycle during active data.
  - Required: all outputs 0 immediately, frame_count=0.
  - Required: first pixel after the next vsync cycle is at (0,0) with frame_start.
